gpr_access_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the `GPR` register file. It shares the single `GPR` read/write port between two requesters: port 0 is the CPU control unit and port 1 is the debug/loader port. It serialises their accesses with a round-robin grant and drives the `GPR_rd`/`GPR_wr` strobes for exactly one cycle per transaction. It captures read results into a holding register, returns a one-cycle acknowledge, and rejects writes to the flags register (index 15), which `GPR` owns.

---
 rtl/gpr_access_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_gpr_access_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_access_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_access_arbiter
//
// Shares the single GPR read/write port between two requesters: port 0
// (CPU control unit) and port 1 (debug/loader).  Contested requests are
// granted round-robin.  Each transaction takes three cycles:
//   IDLE  -> the request is sampled and a port is granted
//   ISSUE -> exactly one GPR strobe is high (none for a rejected write)
//   DONE  -> one-cycle ack (and err) to the granted port
// Writes to register index 15 (flags, owned by GPR) are rejected with err.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req0_i/req1_i                request, held until the matching ack
//   wr0_i/wr1_i                  1 = write, 0 = read
//   addr0_i/addr1_i              GPR address, three REG_W index fields
//   wdata0_i/wdata1_i            write data
//   ack0_o/ack1_o                one-cycle completion pulse
//   err0_o/err1_o                one-cycle pulse with ack: flags write rejected
//   rdata_o                      captured read result, shared by both ports
//   busy_o                       high whenever the FSM is not in IDLE
//   gpr_address_in_o             GPR write address
//   gpr_address_out_o            GPR read address
//   gpr_data_in_o                GPR write data
//   gpr_data_out_i               GPR read data (sum of three registers)
//   GPR_rd_o/GPR_wr_o            registered GPR strobes, high only in ISSUE
// ---------------------------------------------------------------------------
module gpr_access_arbiter #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int REG_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              wr0_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] gpr_address_in_o,
    output logic [ADDR_W-1:0] gpr_address_out_o,
    output logic [DATA_W-1:0] gpr_data_in_o,
    input  logic [DATA_W-1:0] gpr_data_out_i,
    output logic              GPR_rd_o,
    output logic              GPR_wr_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [REG_W-1:0] FLAGS_IDX = {REG_W{1'b1}};

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                gntPort_q, gntPort_d;
    logic                isRead_q, isRead_d;
    logic                reject_q, reject_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    logic                gprRd_q, gprRd_d;
    logic                gprWr_q, gprWr_d;
    logic [ADDR_W-1:0]   gprAddrIn_q, gprAddrIn_d;
    logic [ADDR_W-1:0]   gprAddrOut_q, gprAddrOut_d;
    logic [DATA_W-1:0]   gprDataIn_q, gprDataIn_d;

    logic                anyReq;
    logic                grantPort;
    logic                selWr;
    logic [ADDR_W-1:0]   selAddr;
    logic [DATA_W-1:0]   selWdata;
    logic                selFlags;
    logic                take;

    // State register plus every registered output; reset returns the FSM to
    // IDLE and clears all outputs, so an in-flight transaction is dropped
    // without an ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            gntPort_q    <= 1'b0;
            isRead_q     <= 1'b0;
            reject_q     <= 1'b0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            gprRd_q      <= 1'b0;
            gprWr_q      <= 1'b0;
            gprAddrIn_q  <= '0;
            gprAddrOut_q <= '0;
            gprDataIn_q  <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            gntPort_q    <= gntPort_d;
            isRead_q     <= isRead_d;
            reject_q     <= reject_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            gprRd_q      <= gprRd_d;
            gprWr_q      <= gprWr_d;
            gprAddrIn_q  <= gprAddrIn_d;
            gprAddrOut_q <= gprAddrOut_d;
            gprDataIn_q  <= gprDataIn_d;
        end
    end

    // Next-state logic: a fixed three-cycle walk once any request is seen.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0_i || req1_i) state_d = ISSUE;
            ISSUE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arbitration: a lone requester wins; when both ask, prio names the
    // winner.  The strobes and GPR buses are computed here from the granted
    // request so that they are already registered when ISSUE begins.
    always_comb begin
        anyReq    = req0_i || req1_i;
        grantPort = (req0_i && req1_i) ? prio_q : req1_i;
        selWr     = grantPort ? wr1_i    : wr0_i;
        selAddr   = grantPort ? addr1_i  : addr0_i;
        selWdata  = grantPort ? wdata1_i : wdata0_i;
        selFlags  = (selAddr[ADDR_W-1 -: REG_W] == FLAGS_IDX);
        take      = (state_q == IDLE) && anyReq;
    end

    // Output logic: strobes, ack and err are single-cycle pulses and default
    // low; the GPR buses, rdata and the latched grant hold their values.
    always_comb begin
        prio_d       = prio_q;
        gntPort_d    = gntPort_q;
        isRead_d     = isRead_q;
        reject_d     = reject_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        gprRd_d      = 1'b0;
        gprWr_d      = 1'b0;
        gprAddrIn_d  = gprAddrIn_q;
        gprAddrOut_d = gprAddrOut_q;
        gprDataIn_d  = gprDataIn_q;

        if (take) begin
            gntPort_d = grantPort;
            isRead_d  = !selWr;
            reject_d  = selWr && selFlags;
            // The winner always loses the next contested round.
            prio_d    = !grantPort;
            if (!selWr) begin
                gprRd_d      = 1'b1;
                gprAddrOut_d = selAddr;
            end else if (!selFlags) begin
                gprWr_d     = 1'b1;
                gprAddrIn_d = selAddr;
                gprDataIn_d = selWdata;
            end
        end

        // End of ISSUE: capture the read result and raise the DONE pulses.
        if (state_q == ISSUE) begin
            if (isRead_q) begin
                rdata_d = gpr_data_out_i;
            end
            ack0_d = !gntPort_q;
            ack1_d = gntPort_q;
            err0_d = !gntPort_q && reject_q;
            err1_d = gntPort_q && reject_q;
        end
    end

    assign busy_o            = (state_q != IDLE);
    assign ack0_o            = ack0_q;
    assign ack1_o            = ack1_q;
    assign err0_o            = err0_q;
    assign err1_o            = err1_q;
    assign rdata_o           = rdata_q;
    assign GPR_rd_o          = gprRd_q;
    assign GPR_wr_o          = gprWr_q;
    assign gpr_address_in_o  = gprAddrIn_q;
    assign gpr_address_out_o = gprAddrOut_q;
    assign gpr_data_in_o     = gprDataIn_q;

endmodule

// File: tb/tb_gpr_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpr_access_arbiter
//
// Drives gpr_access_arbiter against a small behavioural GPR (16 registers,
// read data = sum of the three indexed registers).  Expected acks are queued
// when a request is driven and compared when the DUT acknowledges.
// ---------------------------------------------------------------------------
module tb_gpr_access_arbiter;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;
    localparam int REG_W  = 4;

    logic              clk;
    logic              rst;
    logic              req0, req1, wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, err0, err1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] gprAddrIn, gprAddrOut;
    logic [DATA_W-1:0] gprDataIn, gprDataOut;
    logic              gprRd, gprWr;

    logic              modelInit;
    logic [DATA_W-1:0] gprRegs [16];
    logic [DATA_W-1:0] expRegs [16];

    typedef struct {
        logic              port;
        logic              isRead;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                ackCyc;
    } expect_t;

    expect_t           sb[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                rdCount = 0;
    int                wrCount = 0;
    logic [DATA_W-1:0] lastRdata;

    gpr_access_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .REG_W (REG_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req0_i           (req0),
        .req1_i           (req1),
        .wr0_i            (wr0),
        .wr1_i            (wr1),
        .addr0_i          (addr0),
        .addr1_i          (addr1),
        .wdata0_i         (wdata0),
        .wdata1_i         (wdata1),
        .ack0_o           (ack0),
        .ack1_o           (ack1),
        .err0_o           (err0),
        .err1_o           (err1),
        .rdata_o          (rdata),
        .busy_o           (busy),
        .gpr_address_in_o (gprAddrIn),
        .gpr_address_out_o(gprAddrOut),
        .gpr_data_in_o    (gprDataIn),
        .gpr_data_out_i   (gprDataOut),
        .GPR_rd_o         (gprRd),
        .GPR_wr_o         (gprWr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] initVal(int i);
        if (i == 15) return 14'h2A;
        return 14'(i * 7 + 1);
    endfunction

    // Behavioural GPR: write on the strobe, combinational three-register sum.
    always @(posedge clk) begin
        if (modelInit) begin
            for (int i = 0; i < 16; i++) gprRegs[i] <= initVal(i);
        end else if (gprWr) begin
            gprRegs[gprAddrIn[11:8]] <= gprDataIn;
        end
    end

    always_comb begin
        gprDataOut = gprRegs[gprAddrOut[11:8]] + gprRegs[gprAddrOut[7:4]]
                   + gprRegs[gprAddrOut[3:0]];
    end

    function automatic logic [DATA_W-1:0] expSum(logic [ADDR_W-1:0] a);
        return expRegs[a[11:8]] + expRegs[a[7:4]] + expRegs[a[3:0]];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic pushExpected(input logic port, input logic wr,
                                input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int ackCyc);
        expect_t e;
        e.port   = port;
        e.isRead = !wr;
        e.err    = wr && (addr[11:8] == 4'hF);
        e.addr   = addr;
        e.wdata  = wdata;
        if (!wr) lastRdata = expSum(addr);
        else if (!e.err) expRegs[addr[11:8]] = wdata;
        e.rdata  = lastRdata;
        e.ackCyc = ackCyc;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic port, input logic wr,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        if (port) begin
            req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wdata;
        end
        pushExpected(port, wr, addr, wdata, cyc + 2);
    endtask

    task automatic dropReqs();
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    endtask

    // Sampled at the falling edge: strobe sanity, strobe contents against the
    // head of the scoreboard, and the ack comparison itself.
    task automatic observe();
        expect_t e;
        if (ack0 && ack1) checkOutput("ackOverlap", 32'(1), 32'(0));
        if (gprRd && gprWr) checkOutput("strobeExcl", 32'(1), 32'(0));
        if ((gprRd || gprWr) && !busy) checkOutput("strobeBusy", 32'(busy), 32'(1));
        if (rst) begin
            rdCount = 0;
            wrCount = 0;
        end else begin
            if (gprRd) begin
                rdCount++;
                if (sb.size() == 0) checkOutput("strayRd", 32'(1), 32'(0));
                else checkOutput("rdAddr", 32'(gprAddrOut), 32'(sb[0].addr));
            end
            if (gprWr) begin
                wrCount++;
                if (sb.size() == 0) checkOutput("strayWr", 32'(1), 32'(0));
                else begin
                    checkOutput("wrAddr", 32'(gprAddrIn), 32'(sb[0].addr));
                    checkOutput("wrData", 32'(gprDataIn), 32'(sb[0].wdata));
                end
            end
        end
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                checkOutput("strayAck", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("ackPort", 32'(ack1), 32'(e.port));
                checkOutput("ackCycle", 32'(cyc), 32'(e.ackCyc));
                checkOutput("err0", 32'(err0), 32'(e.err && !e.port));
                checkOutput("err1", 32'(err1), 32'(e.err && e.port));
                checkOutput("rdata", 32'(rdata), 32'(e.rdata));
                checkOutput("rdStrobes", 32'(rdCount), 32'(e.isRead));
                checkOutput("wrStrobes", 32'(wrCount), 32'(!e.isRead && !e.err));
            end
            rdCount = 0;
            wrCount = 0;
        end else if (err0 || err1) begin
            checkOutput("strayErr", 32'(1), 32'(0));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitDone(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            tick();
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            checkOutput("ackTimeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; modelInit = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 16; i++) expRegs[i] = initVal(i);
        lastRdata = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a pending read on port 0.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rstBusy", 32'(busy), 32'(0));
            checkOutput("rstStrobes", 32'({gprRd, gprWr}), 32'(0));
            checkOutput("rstAcks", 32'({ack0, ack1, err0, err1}), 32'(0));
            if (i == 1) begin
                checkOutput("rstRdata", 32'(rdata), 32'(0));
                checkOutput("rstAddrIn", 32'(gprAddrIn), 32'(0));
                checkOutput("rstAddrOut", 32'(gprAddrOut), 32'(0));
                checkOutput("rstDataIn", 32'(gprDataIn), 32'(0));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0; modelInit = 1'b0;
        pushExpected(1'b0, 1'b0, 12'h000, 14'h0, cyc + 2);
        waitDone(10);
        dropReqs();

        // Port 0 write reg 1 = 5, then read 1+1+1.
        tick();
        applyStimulus(1'b0, 1'b1, 12'h100, 14'h0005);
        waitDone(10);
        dropReqs();
        tick();
        applyStimulus(1'b0, 1'b0, 12'h111, 14'h0);
        waitDone(10);
        dropReqs();

        // Contention from reset: grants alternate 0,1,0,1 three cycles apart.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        lastRdata = '0;
        applyStimulus(1'b0, 1'b0, 12'h123, 14'h0);
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h789;
        pushExpected(1'b1, 1'b0, 12'h789, 14'h0, cyc + 5);
        pushExpected(1'b0, 1'b0, 12'h123, 14'h0, cyc + 8);
        pushExpected(1'b1, 1'b0, 12'h789, 14'h0, cyc + 11);
        waitDone(20);
        dropReqs();

        // Flags write rejected, then flags register read back untouched.
        tick();
        applyStimulus(1'b1, 1'b1, 12'hF00, 14'h1234);
        waitDone(10);
        dropReqs();
        tick();
        applyStimulus(1'b1, 1'b0, 12'hFFF, 14'h0);
        waitDone(10);
        dropReqs();

        // Reset during ISSUE of a read: no ack, back to IDLE, rdata cleared.
        tick();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h222;
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortStrobe", 32'(gprRd), 32'(1));
        observe();
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        checkOutput("abortAck", 32'({ack0, ack1}), 32'(0));
        checkOutput("abortBusy", 32'(busy), 32'(0));
        checkOutput("abortStrobeOff", 32'({gprRd, gprWr}), 32'(0));
        checkOutput("abortRdata", 32'(rdata), 32'(0));
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        lastRdata = '0;
        dropReqs();
        tick();
        applyStimulus(1'b1, 1'b0, 12'h321, 14'h0);
        waitDone(10);
        dropReqs();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
